// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling and frame-error detection
module uart_rx #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       donerx,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CYC = clk_freq / baud_rate;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    rx_data_n;
  logic          donerx_n, frame_err_n;
  logic          rx_m, rx_s;

  // Two-flop synchronizer; both stages reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // State and datapath registers; a reset mid-frame simply discards the partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      rx_data   <= '0;
      donerx    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      rx_data   <= rx_data_n;
      donerx    <= donerx_n;
      frame_err <= frame_err_n;
    end
  end

  // Next-state logic: half-bit wait to centre on the start bit, then one sample per bit time.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shift_n     = shift;
    rx_data_n   = rx_data;
    donerx_n    = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n        = '0;
          shift_n[idx] = rx_s;
          if (idx == 3'd7) begin
            idx_n   = '0;
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            rx_data_n = shift;
            donerx_n  = 1'b1;
            state_n   = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BREAK: begin
        // A line held low after a bad stop bit must not look like a new start.
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;

  localparam int BIT  = 104;
  localparam int HALF = 52;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       donerx;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .clk_freq (1000000),
    .baud_rate(9600)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .donerx   (donerx),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned done_cyc[$];
  int          passed = 0;
  int          total  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(string name, int act, int lo, int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic expect_byte(logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = held;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(logic b, int bc);
    rx = b;
    repeat (bc) @(negedge clk);
  endtask

  task automatic send_frame(logic [7:0] d, int bc, logic stop);
    send_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) send_bit(d[i], bc);
    send_bit(stop, bc);
  endtask

  task automatic idle(int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every donerx/frame_err pulse is matched against the head of the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (donerx || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, donerx, frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {30'd0, donerx, frame_err}, e.is_err ? 32'd1 : 32'd2);
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        if (donerx) done_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    int unsigned fall;
    int          bcs[2];
    bcs[0] = 107;
    bcs[1] = 101;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_donerx", {31'd0, donerx}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    idle(20);

    // 1: single frame 0xA5, latency from first edge seeing rx low (990, +/-1)
    expect_byte(8'hA5);
    fall = cyc;
    send_bit(1'b0, BIT);
    check("t1_busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) send_bit(i[0] ? (8'hA5 >> i) & 1 : (8'hA5 >> i) & 1, BIT);
    send_bit(1'b1, BIT);
    idle(BIT);
    check("t1_done_count", done_cyc.size(), 32'd1);
    if (done_cyc.size() > 0) check_range("t1_latency", int'(done_cyc[0] - fall), 990, 992);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2: back-to-back 0x00 then 0xFF, no idle gap
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_frame(8'h00, BIT, 1'b1);
    send_frame(8'hFF, BIT, 1'b1);
    idle(2 * BIT);
    check("t2_done_count", done_cyc.size(), 32'd3);
    if (done_cyc.size() >= 3) check_range("t2_gap", int'(done_cyc[2] - done_cyc[1]), 988, 1042);

    // 3: 20-cycle glitch is rejected in START
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("t3_busy_glitch", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (HALF + 3) @(negedge clk);
    check("t3_busy_dropped", {31'd0, busy}, 32'd0);
    idle(BIT);

    // 4: bad stop bit on 0x3C, line held low, then a good 0x5A
    expect_err(8'hFF);
    send_frame(8'h3C, BIT, 1'b0);
    rx = 1'b0;
    repeat (300) @(negedge clk);
    check("t4_busy_break", {31'd0, busy}, 32'd1);
    check("t4_rx_data_held", {24'd0, rx_data}, 32'hFF);
    idle(BIT);
    check("t4_busy_released", {31'd0, busy}, 32'd0);
    expect_byte(8'h5A);
    send_frame(8'h5A, BIT, 1'b1);
    idle(BIT);

    // 5: reset during data bit 4 of 0x81
    send_bit(1'b0, BIT);
    send_bit(1'b1, BIT);
    send_bit(1'b0, BIT);
    send_bit(1'b0, BIT);
    send_bit(1'b0, BIT);
    send_bit(1'b0, BIT / 2);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_rx_data_reset", {24'd0, rx_data}, 32'd0);
    check("t5_donerx_reset", {31'd0, donerx}, 32'd0);
    check("t5_frame_err_reset", {31'd0, frame_err}, 32'd0);
    check("t5_busy_reset", {31'd0, busy}, 32'd0);
    idle(2 * BIT);
    expect_byte(8'h3C);
    send_frame(8'h3C, BIT, 1'b1);
    idle(BIT);
    check("t5_rx_data_next", {24'd0, rx_data}, 32'h3C);

    // 6: +3% and -3% bit times
    for (int k = 0; k < 2; k++) begin
      expect_byte(8'h55);
      send_frame(8'h55, bcs[k], 1'b1);
      idle(bcs[k]);
      expect_byte(8'hC3);
      send_frame(8'hC3, bcs[k], 1'b1);
      idle(bcs[k]);
    end

    idle(BIT);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
